// File: rtl/fpu_issue_if.sv
// ======================================================================
// fpu_issue_if : CPU / FP-load / coprocessor / store bundle for fpu_issue_ctrl
// Revision 1.0
// ======================================================================
`default_nettype none

interface fpu_issue_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [5:0]  instr_opcode;
    logic [4:0]  instr_rs;
    logic [4:0]  instr_rt;
    logic [4:0]  instr_rd;

    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_addr;
    logic [31:0] ld_data;

    logic [5:0]  cop_opcode;
    logic [4:0]  cop_addr_in1;
    logic [4:0]  cop_addr_in2;
    logic [4:0]  cop_addr_dest;
    logic [4:0]  cop_write_address;
    logic [31:0] cop_inputdata;
    logic        cop_write_enable;
    logic [31:0] cop_outdata;

    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_data;

    modport master (
        output instr_valid, instr_opcode, instr_rs, instr_rt, instr_rd,
        output ld_valid, ld_addr, ld_data, cop_outdata, st_ready,
        input  instr_ready, ld_ready, cop_opcode, cop_addr_in1, cop_addr_in2,
        input  cop_addr_dest, cop_write_address, cop_inputdata, cop_write_enable,
        input  st_valid, st_data
    );

    modport slave (
        input  instr_valid, instr_opcode, instr_rs, instr_rt, instr_rd,
        input  ld_valid, ld_addr, ld_data, cop_outdata, st_ready,
        output instr_ready, ld_ready, cop_opcode, cop_addr_in1, cop_addr_in2,
        output cop_addr_dest, cop_write_address, cop_inputdata, cop_write_enable,
        output st_valid, st_data
    );
endinterface

`default_nettype wire

// File: rtl/fpu_issue_ctrl.sv
// ======================================================================
// fpu_issue_ctrl : instruction FIFO plus issue/latency FSM for an FP coprocessor
// Revision 1.0
// ======================================================================
`default_nettype none

module fpu_issue_ctrl #(
    parameter int DEPTH   = 4,
    parameter int LAT_ADD = 1,
    parameter int LAT_MUL = 2,
    parameter int LAT_DIV = 4
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    input  wire logic   cache_done,
    output logic        cop_cache_done,
    output logic        busy,
    output logic        illegal,
    fpu_issue_if.slave  bus
);
    localparam int AW      = $clog2(DEPTH);
    localparam int LAT_MAX = (LAT_DIV > LAT_MUL) ? ((LAT_DIV > LAT_ADD) ? LAT_DIV : LAT_ADD)
                                                 : ((LAT_MUL > LAT_ADD) ? LAT_MUL : LAT_ADD);
    localparam int CW      = $clog2(LAT_MAX + 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    localparam logic [5:0] OP_NOP = 6'b000000;
    localparam logic [5:0] OP_ADD = 6'b110000;
    localparam logic [5:0] OP_SUB = 6'b110001;
    localparam logic [5:0] OP_MUL = 6'b110010;
    localparam logic [5:0] OP_DIV = 6'b110011;
    localparam logic [5:0] OP_CMP = 6'b110100;
    localparam logic [5:0] OP_RCP = 6'b110101;
    localparam logic [5:0] OP_RND = 6'b110110;
    localparam logic [5:0] OP_SW  = 6'b001011;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_SCAP  = 3'd4,
        S_SHOLD = 3'd5
    } state_t;

    function automatic logic op_legal(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_CMP, OP_RCP, OP_RND, OP_SW: op_legal = 1'b1;
            default: op_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [CW-1:0] lat_m1(input logic [5:0] op);
        case (op)
            OP_MUL:         lat_m1 = CW'(LAT_MUL - 1);
            OP_DIV, OP_RCP: lat_m1 = CW'(LAT_DIV - 1);
            default:        lat_m1 = CW'(LAT_ADD - 1);
        endcase
    endfunction

    // FIFO entry layout: {opcode[20:15], rs[14:10], rt[9:5], rd[4:0]}
    logic [20:0]   r_mem [DEPTH];
    logic [AW:0]   r_wr_ptr, r_rd_ptr;
    logic [20:0]   r_cmd;
    logic [4:0]    r_ld_addr;
    logic [31:0]   r_ld_data;
    logic [31:0]   r_st_data;
    logic [CW-1:0] r_cnt;
    logic          r_started;
    state_t        r_state;

    state_t        w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic [20:0]   w_head;
    logic          w_empty, w_full, w_push, w_pop, w_cmd_load, w_ld_take, w_st_cap;

    assign w_empty         = (r_wr_ptr == r_rd_ptr);
    assign w_full          = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                             (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push          = bus.instr_valid && !w_full;
    assign w_head          = r_mem[r_rd_ptr[AW-1:0]];
    assign bus.instr_ready = !w_full;
    assign bus.st_data     = r_st_data;
    assign busy            = (r_state != S_IDLE) || !w_empty;
    assign cop_cache_done  = cache_done;

    always_comb begin
        w_state_nxt           = r_state;
        w_cnt_nxt             = r_cnt;
        w_pop                 = 1'b0;
        w_cmd_load            = 1'b0;
        w_ld_take             = 1'b0;
        w_st_cap              = 1'b0;
        illegal               = 1'b0;
        bus.ld_ready          = 1'b0;
        bus.st_valid          = 1'b0;
        bus.cop_opcode        = OP_NOP;
        bus.cop_addr_in1      = '0;
        bus.cop_addr_in2      = '0;
        bus.cop_addr_dest     = '0;
        bus.cop_write_enable  = 1'b0;
        bus.cop_write_address = '0;
        bus.cop_inputdata     = '0;

        // A stall freezes every transition; only the FIFO write side keeps moving.
        if (!cache_done) begin
            unique case (r_state)
                S_IDLE: begin
                    if (r_started) begin
                        bus.ld_ready = 1'b1;
                        if (bus.ld_valid) begin
                            w_ld_take   = 1'b1;
                            w_state_nxt = S_LOAD;
                        end else if (!w_empty) begin
                            w_pop = 1'b1;
                            if (op_legal(w_head[20:15])) begin
                                w_cmd_load  = 1'b1;
                                w_state_nxt = S_ISSUE;
                            end else begin
                                illegal = 1'b1;
                            end
                        end
                    end
                end
                S_LOAD:  w_state_nxt = S_IDLE;
                S_ISSUE: begin
                    if (r_cmd[20:15] == OP_SW) begin
                        w_state_nxt = S_SCAP;
                    end else begin
                        w_cnt_nxt   = lat_m1(r_cmd[20:15]);
                        w_state_nxt = (w_cnt_nxt != '0) ? S_WAIT : S_IDLE;
                    end
                end
                S_WAIT: begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                    if (w_cnt_nxt == '0) w_state_nxt = S_IDLE;
                end
                S_SCAP: begin
                    w_st_cap    = 1'b1;
                    w_state_nxt = S_SHOLD;
                end
                S_SHOLD: begin
                    // valid is withheld while stalled so a frozen SHOLD cannot hand off twice
                    bus.st_valid = 1'b1;
                    if (bus.st_ready) w_state_nxt = S_IDLE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end

        if (r_state == S_ISSUE) begin
            bus.cop_opcode    = r_cmd[20:15];
            bus.cop_addr_in1  = r_cmd[9:5];
            bus.cop_addr_in2  = r_cmd[14:10];
            bus.cop_addr_dest = r_cmd[4:0];
        end
        if (r_state == S_LOAD) begin
            bus.cop_write_enable  = 1'b1;
            bus.cop_write_address = r_ld_addr;
            bus.cop_inputdata     = r_ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_started <= 1'b0;
            r_cnt     <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_cmd     <= '0;
            r_ld_addr <= '0;
            r_ld_data <= '0;
            r_st_data <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_started <= 1'b1;
            r_cnt     <= w_cnt_nxt;
            if (w_push)     r_wr_ptr  <= r_wr_ptr + 1'b1;
            if (w_pop)      r_rd_ptr  <= r_rd_ptr + 1'b1;
            if (w_cmd_load) r_cmd     <= w_head;
            if (w_ld_take) begin
                r_ld_addr <= bus.ld_addr;
                r_ld_data <= bus.ld_data;
            end
            if (w_st_cap)   r_st_data <= bus.cop_outdata;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr[AW-1:0]] <= {bus.instr_opcode, bus.instr_rs, bus.instr_rt, bus.instr_rd};
    end
endmodule

`default_nettype wire

// File: tb/tb_fpu_issue_ctrl.sv
// ======================================================================
// tb_fpu_issue_ctrl : directed + random bench with a slot-schedule reference model
// Revision 1.0
// ======================================================================
`default_nettype none

module tb_fpu_issue_ctrl;
    localparam int DEPTH = 4, LAT_ADD = 1, LAT_MUL = 2, LAT_DIV = 4;
    localparam logic [5:0] OP_ADD = 6'b110000, OP_MUL = 6'b110010, OP_DIV = 6'b110011;
    localparam logic [5:0] OP_SW  = 6'b001011, OP_BAD = 6'b111111;

    logic clk = 1'b0, rst_n = 1'b1, cache_done = 1'b0;
    logic cop_cache_done, busy, illegal;
    int   n_checks = 0, n_fail = 0;

    fpu_issue_if bus();

    fpu_issue_ctrl #(.DEPTH(DEPTH), .LAT_ADD(LAT_ADD), .LAT_MUL(LAT_MUL), .LAT_DIV(LAT_DIV)) dut (
        .clk(clk), .rst_n(rst_n), .cache_done(cache_done),
        .cop_cache_done(cop_cache_done), .busy(busy), .illegal(illegal), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic bit legal(input logic [5:0] op);
        return op inside {6'b110000, 6'b110001, 6'b110010, 6'b110011,
                          6'b110100, 6'b110101, 6'b110110, 6'b001011};
    endfunction

    function automatic int lat_of(input logic [5:0] op);
        if (op == 6'b110010) return LAT_MUL;
        if (op == 6'b110011 || op == 6'b110101) return LAT_DIV;
        return LAT_ADD;
    endfunction

    // Reference model: a queue of pending instructions and a schedule of
    // output slots; each un-stalled cycle consumes the head slot.
    typedef struct { logic [5:0] op; logic [4:0] rs, rt, rd; } instr_t;
    typedef enum int { K_LOAD, K_CMD, K_WAIT, K_CAP, K_HOLD } kind_t;
    typedef struct { kind_t kind; instr_t ins; logic [4:0] addr; logic [31:0] data; } slot_t;

    instr_t      mq[$];
    slot_t       sched[$];
    logic [31:0] m_st_data = '0;
    bit          m_started = 1'b0;

    always @(negedge clk) begin : cmp
        logic [5:0]  e_op;
        logic [4:0]  e_in1, e_in2, e_dest, e_wa;
        logic [31:0] e_wd;
        logic        e_we, e_stv, e_ldr, e_ill, e_busy, e_ir;
        slot_t       s;
        instr_t      h, incoming;
        bit          push_ok;

        e_op = '0; e_in1 = '0; e_in2 = '0; e_dest = '0; e_wa = '0; e_wd = '0;
        e_we = 1'b0; e_stv = 1'b0; e_ldr = 1'b0; e_ill = 1'b0;
        if (!rst_n) begin
            mq.delete();
            sched.delete();
            m_st_data = '0;
            m_started = 1'b0;
            e_busy = 1'b0;
            e_ir   = 1'b1;
        end else begin
            e_ldr = m_started && (sched.size() == 0) && !cache_done;
            if (e_ldr && !bus.ld_valid && mq.size() != 0) begin
                h = mq[0];
                e_ill = !legal(h.op);
            end
            if (sched.size() != 0) begin
                s = sched[0];
                case (s.kind)
                    K_LOAD: begin e_we = 1'b1; e_wa = s.addr; e_wd = s.data; end
                    K_CMD:  begin e_op = s.ins.op; e_in1 = s.ins.rt; e_in2 = s.ins.rs; e_dest = s.ins.rd; end
                    K_HOLD: e_stv = !cache_done;
                    default: ;
                endcase
            end
            e_busy = (sched.size() != 0) || (mq.size() != 0);
            e_ir   = (mq.size() < DEPTH);
        end

        chk("cop_opcode", bus.cop_opcode, e_op);
        chk("cop_addr_in1", bus.cop_addr_in1, e_in1);
        chk("cop_addr_in2", bus.cop_addr_in2, e_in2);
        chk("cop_addr_dest", bus.cop_addr_dest, e_dest);
        chk("cop_write_enable", bus.cop_write_enable, e_we);
        chk("cop_write_address", bus.cop_write_address, e_wa);
        chk("cop_inputdata", bus.cop_inputdata, e_wd);
        chk("st_valid", bus.st_valid, e_stv);
        chk("st_data", bus.st_data, m_st_data);
        chk("ld_ready", bus.ld_ready, e_ldr);
        chk("illegal", illegal, e_ill);
        chk("busy", busy, e_busy);
        chk("instr_ready", bus.instr_ready, e_ir);
        chk("cop_cache_done", cop_cache_done, cache_done);

        if (rst_n) begin
            push_ok  = bus.instr_valid && (mq.size() < DEPTH);
            incoming = '{bus.instr_opcode, bus.instr_rs, bus.instr_rt, bus.instr_rd};
            if (!cache_done) begin
                if (sched.size() == 0) begin
                    if (m_started) begin
                        if (bus.ld_valid) begin
                            s.kind = K_LOAD; s.addr = bus.ld_addr; s.data = bus.ld_data;
                            sched.push_back(s);
                        end else if (mq.size() != 0) begin
                            h = mq.pop_front();
                            if (legal(h.op)) begin
                                s.kind = K_CMD; s.ins = h;
                                sched.push_back(s);
                                if (h.op == OP_SW) begin
                                    s.kind = K_CAP;  sched.push_back(s);
                                    s.kind = K_HOLD; sched.push_back(s);
                                end else begin
                                    for (int i = 1; i < lat_of(h.op); i++) begin
                                        s.kind = K_WAIT; sched.push_back(s);
                                    end
                                end
                            end
                        end
                    end
                end else begin
                    s = sched[0];
                    if (s.kind == K_HOLD) begin
                        if (bus.st_ready) void'(sched.pop_front());
                    end else begin
                        if (s.kind == K_CAP) m_st_data = bus.cop_outdata;
                        void'(sched.pop_front());
                    end
                end
            end
            if (push_ok) mq.push_back(incoming);
            m_started = 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic v, input logic [5:0] op,
                             input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        bus.instr_valid = v; bus.instr_opcode = op;
        bus.instr_rs = rs; bus.instr_rt = rt; bus.instr_rd = rd;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (busy && n < budget) begin
            step();
            n++;
        end
        chk(name, busy, 1'b0);
    endtask

    logic [5:0] ops [10] = '{6'b110000, 6'b110001, 6'b110010, 6'b110011, 6'b110100,
                             6'b110101, 6'b110110, 6'b001011, 6'b111111, 6'b000111};

    initial begin
        set_instr(1'b0, 6'd0, 5'd0, 5'd0, 5'd0);
        bus.ld_valid = 1'b0; bus.ld_addr = '0; bus.ld_data = '0;
        bus.cop_outdata = '0; bus.st_ready = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) step();
        chk("rst_busy", busy, 1'b0);
        chk("rst_cop_opcode", bus.cop_opcode, 6'd0);
        chk("rst_st_valid", bus.st_valid, 1'b0);
        chk("rst_ld_ready", bus.ld_ready, 1'b0);
        rst_n = 1'b1;
        #1 chk("ld_ready_first_cycle", bus.ld_ready, 1'b0);

        // two register loads
        bus.ld_valid = 1'b1; bus.ld_addr = 5'd3; bus.ld_data = 32'h3F80_0000;
        step(); #1 chk("ld_ready_idle", bus.ld_ready, 1'b1);
        step();
        bus.ld_addr = 5'd4; bus.ld_data = 32'h4000_0000;
        #1 chk("load1_we", bus.cop_write_enable, 1'b1);
        chk("load1_addr", bus.cop_write_address, 5'd3);
        chk("load1_data", bus.cop_inputdata, 32'h3F80_0000);
        chk("load1_ld_ready", bus.ld_ready, 1'b0);
        step(); #1 chk("load_gap_we", bus.cop_write_enable, 1'b0);
        step(); bus.ld_valid = 1'b0;
        #1 chk("load2_addr", bus.cop_write_address, 5'd4);
        chk("load2_data", bus.cop_inputdata, 32'h4000_0000);
        step(); #1 chk("load2_end_we", bus.cop_write_enable, 1'b0);

        // add then mul
        set_instr(1'b1, OP_ADD, 5'd1, 5'd2, 5'd5); step();
        set_instr(1'b1, OP_MUL, 5'd3, 5'd4, 5'd6); step();
        bus.instr_valid = 1'b0;
        #1 chk("add_op", bus.cop_opcode, OP_ADD);
        chk("add_in1_rt", bus.cop_addr_in1, 5'd2);
        chk("add_in2_rs", bus.cop_addr_in2, 5'd1);
        chk("add_dest", bus.cop_addr_dest, 5'd5);
        step(); #1 chk("add_one_cycle", bus.cop_opcode, 6'd0);
        step(); #1 chk("mul_op", bus.cop_opcode, OP_MUL);
        chk("mul_dest", bus.cop_addr_dest, 5'd6);
        step(); #1 chk("mul_wait_op", bus.cop_opcode, 6'd0);
        chk("mul_wait_busy", busy, 1'b1);
        step(); #1 chk("mul_done_busy", busy, 1'b0);

        // store with back-pressure
        bus.cop_outdata = 32'h4040_0000;
        set_instr(1'b1, OP_SW, 5'd5, 5'd0, 5'd0); step();
        bus.instr_valid = 1'b0; step();
        #1 chk("sw_op", bus.cop_opcode, OP_SW);
        chk("sw_in2_rs", bus.cop_addr_in2, 5'd5);
        step(); step();
        bus.cop_outdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("sw_hold_valid", bus.st_valid, 1'b1);
            chk("sw_hold_data", bus.st_data, 32'h4040_0000);
            if (i < 2) step();
        end
        bus.st_ready = 1'b1; step(); bus.st_ready = 1'b0;
        #1 chk("sw_released_valid", bus.st_valid, 1'b0);
        chk("sw_released_busy", busy, 1'b0);
        chk("sw_data_kept", bus.st_data, 32'h4040_0000);

        // divide stalled during issue
        set_instr(1'b1, OP_DIV, 5'd1, 5'd2, 5'd7); step();
        bus.instr_valid = 1'b0; step();
        cache_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("div_held_op", bus.cop_opcode, OP_DIV);
            step();
        end
        cache_done = 1'b0;
        #1 chk("div_issue_op", bus.cop_opcode, OP_DIV);
        for (int i = 0; i < 3; i++) begin
            step(); #1 chk("div_wait_busy", busy, 1'b1);
            chk("div_wait_op", bus.cop_opcode, 6'd0);
        end
        step(); #1 chk("div_done_busy", busy, 1'b0);

        // fill while stalled, illegal head
        cache_done = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_instr(1'b1, (i == 0) ? OP_BAD : OP_ADD, 5'd1, 5'd1, 5'd1);
            step();
        end
        bus.instr_valid = 1'b0;
        #1 chk("full_instr_ready", bus.instr_ready, 1'b0);
        cache_done = 1'b0;
        #1 chk("illegal_pulse", illegal, 1'b1);
        chk("illegal_no_op", bus.cop_opcode, 6'd0);
        step(); #1 chk("illegal_one_cycle", illegal, 1'b0);
        chk("after_illegal_op", bus.cop_opcode, 6'd0);
        step(); #1 chk("after_illegal_add", bus.cop_opcode, OP_ADD);
        wait_idle(50, "drain_after_fill");

        // reset during divide wait
        set_instr(1'b1, OP_DIV, 5'd1, 5'd2, 5'd7); step();
        set_instr(1'b1, OP_ADD, 5'd1, 5'd2, 5'd3); step();
        set_instr(1'b1, OP_MUL, 5'd1, 5'd2, 5'd3); step();
        bus.instr_valid = 1'b0;
        #1 chk("pre_rst_busy", busy, 1'b1);
        #1 rst_n = 1'b0;
        #1 chk("async_rst_busy", busy, 1'b0);
        chk("async_rst_op", bus.cop_opcode, 6'd0);
        chk("async_rst_st_data", bus.st_data, 32'h0);
        chk("async_rst_ld_ready", bus.ld_ready, 1'b0);
        chk("async_rst_instr_ready", bus.instr_ready, 1'b1);
        step(); step();
        rst_n = 1'b1;
        repeat (3) begin
            step(); #1 chk("post_rst_busy", busy, 1'b0);
            chk("post_rst_op", bus.cop_opcode, 6'd0);
        end

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            cache_done       = ($urandom_range(0, 7) == 0);
            bus.instr_valid  = $urandom_range(0, 1);
            bus.instr_opcode = ops[$urandom_range(0, 9)];
            bus.instr_rs     = 5'($urandom);
            bus.instr_rt     = 5'($urandom);
            bus.instr_rd     = 5'($urandom);
            bus.ld_valid     = ($urandom_range(0, 5) == 0);
            bus.ld_addr      = 5'($urandom);
            bus.ld_data      = $urandom;
            bus.st_ready     = $urandom_range(0, 1);
            bus.cop_outdata  = $urandom;
            step();
        end
        cache_done = 1'b0; bus.instr_valid = 1'b0; bus.ld_valid = 1'b0; bus.st_ready = 1'b1;
        wait_idle(100, "final_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/fpu_issue_ctrl.md
FPU_ISSUE_CTRL -- requirements
Module: fpu_issue_ctrl

Interface
REQ-001 Parameter DEPTH, 4, instruction FIFO entries (power of 2, >=2).
REQ-002 Parameter LAT_ADD, 1, cycles reserved for add/sub/cmp/rnd/sw (opcodes 110000,110001,110100,110110,001011).
REQ-003 Parameter LAT_MUL, 2, cycles reserved for mul (110010).
REQ-004 Parameter LAT_DIV, 4, cycles reserved for div/reciprocal (110011,110101).
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 instr_valid/instr_ready  in/out  1/1  CPU instruction handshake; transfer when both high.
REQ-008 instr_opcode, instr_rs, instr_rt, instr_rd  in  6,5,5,5  opcode, source1, source2, destination.
REQ-009 ld_valid/ld_ready  in/out  1/1  FP register load handshake; ld_addr in 5, ld_data in 32.
REQ-010 cache_done  in  1  memory stall; high freezes the block and the coprocessor.
REQ-011 cop_opcode, cop_addr_in1, cop_addr_in2, cop_addr_dest  out  6,5,5,5  coprocessor command.
REQ-012 cop_write_address out 5, cop_inputdata out 32, cop_write_enable out 1  coprocessor register load.
REQ-013 cop_cache_done  out  1  equals cache_done (combinational pass-through).
REQ-014 cop_outdata  in  32  coprocessor store data.
REQ-015 st_valid/st_ready  out/in  1/1, st_data out 32  store result handshake.
REQ-016 busy out 1 (state != IDLE or FIFO non-empty); illegal out 1 (one-cycle pulse).

Function
REQ-017 FIFO of DEPTH {opcode,rs,rt,rd}; instr_ready = !full; push on handshake; simultaneous push/pop when full SHALL NOT be accepted (ready already low).
REQ-018 States: IDLE, LOAD, ISSUE, WAIT, SCAP, SHOLD.
REQ-019 Outside ISSUE, cop_opcode SHALL be 6'b000000 (NOP); outside LOAD, cop_write_enable SHALL be 0.
REQ-020 Any state with cache_done=1: state, counter, FIFO pointers and st_data frozen; ld_ready=0; instr pushes still accepted.
REQ-021 IDLE, cache_done=0: ld_ready=1; ld handshake -> LOAD (priority over FIFO); else FIFO non-empty -> pop head into command register -> ISSUE.
REQ-022 Popped head with opcode outside the eight legal codes: discarded, illegal pulses the pop cycle, stay IDLE.
REQ-023 LOAD: drive cop_write_enable=1, cop_write_address/cop_inputdata from captured ld_addr/ld_data for exactly one cycle -> IDLE.
REQ-024 ISSUE: drive command for exactly one un-stalled cycle (never re-presented, since coprocessor ops are non-idempotent); if cache_done=1 remain in ISSUE.
REQ-025 Leaving ISSUE: sw -> SCAP; else counter = LAT-1, -> WAIT if counter>0 else IDLE.
REQ-026 WAIT: decrement counter each un-stalled cycle; at 0 -> IDLE.
REQ-027 SCAP: st_data <= cop_outdata -> SHOLD; SHOLD: st_valid=1, hold st_data until st_ready -> IDLE.
REQ-028 cop_addr_in1=rt, cop_addr_in2=rs, cop_addr_dest=rd of the issuing instruction.
REQ-029 Throughput: LAT_ADD=1 ops issue back-to-back every 2 cycles (ISSUE, IDLE).

Reset
REQ-030 rst_n low: state=IDLE, FIFO empty, counter=0, cop_opcode=0, cop_write_enable=0, addresses/data=0, st_valid=0, st_data=0, illegal=0, ld_ready=0 until first post-reset cycle.
REQ-031 Reset mid-operation (any state) SHALL abandon in-flight command and FIFO contents; no further command driven.

Verification
REQ-032 Load ld_addr=3 ld_data=0x3F800000, then addr 4 0x40000000 -> two one-cycle cop_write_enable pulses in order, ld_ready low while LOAD.
REQ-033 Push add(110000) rd=5, mul(110010) rd=6 -> cop_opcode nonzero exactly 1 cycle each; mul issue followed by 1 WAIT cycle; busy falls after mul.
REQ-034 Push sw rs=5, coprocessor returns 0x40400000, st_ready low 3 cycles -> st_valid held, st_data stable 0x40400000, released on st_ready.
REQ-035 cache_done=1 during ISSUE of div for 3 cycles -> command held, no WAIT decrement; after release exactly 4 reserved cycles.
REQ-036 Fill FIFO with 4 entries while stalled -> instr_ready=0; illegal opcode 111111 popped -> illegal pulse, no cop_opcode activity.
REQ-037 Assert rst_n low during WAIT of div -> all outputs at reset values asynchronously; FIFO empty after release.
